// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning the MIPS HI/LO pair.
// Define HILO_MULDIV_FAST_MULT_EN for single-cycle multiplies.
module hilo_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            hi_we_i,
    input  logic            lo_we_i,
    input  logic [XLEN-1:0] write_data_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            div_zero_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] m_q, m_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            done_q, done_d;
    logic            dz_q, dz_d;

    logic            in_sa, in_sb;
    logic [XLEN-1:0] in_amag, in_bmag;
    logic [W2-1:0]   launch_acc;
    logic [XLEN-1:0] launch_m;
    state_e          launch_state;
    logic            launch;

    logic [XLEN:0]   msum, rem, dsub;
    logic [W2-1:0]   mul_next, div_next, prod;
    logic [XLEN-1:0] quo, rmd;
    logic            div_zero;

    assign in_sa   = ~op_i[0] & operand_a_i[XLEN-1];
    assign in_sb   = ~op_i[0] & operand_b_i[XLEN-1];
    assign in_amag = in_sa ? -operand_a_i : operand_a_i;
    assign in_bmag = in_sb ? -operand_b_i : operand_b_i;

    // m_q holds the multiplicand for multiplies and the divisor for divides
    always_comb begin
        launch_acc   = {{XLEN{1'b0}}, op_i[1] ? in_amag : in_bmag};
        launch_m     = op_i[1] ? in_bmag : in_amag;
        launch_state = S_RUN;
`ifdef HILO_MULDIV_FAST_MULT_EN
        if (!op_i[1]) begin
            launch_acc   = {{XLEN{1'b0}}, in_amag} * {{XLEN{1'b0}}, in_bmag};
            launch_state = S_FINISH;
        end
`endif
    end

    assign msum     = {1'b0, acc_q[W2-1:XLEN]}
                    + {1'b0, m_q & {XLEN{acc_q[0]}}};
    assign mul_next = {msum, acc_q[XLEN-1:1]};

    assign rem      = acc_q[W2-1:XLEN-1];
    assign dsub     = rem - {1'b0, m_q};
    assign div_next = dsub[XLEN]
                    ? {rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                    : {dsub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // a zero divisor leaves the dividend magnitude as remainder, so the
    // normal remainder sign fix-up restores operand_a exactly
    assign prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo      = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rmd      = sa_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
    assign div_zero = ~|m_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        launch  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (hi_we_i) hi_d = write_data_i;
                if (lo_we_i) lo_d = write_data_i;
                launch = start_i;
            end
            S_RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FINISH;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (op_q[1]) begin
                    dz_d = div_zero;
                    lo_d = div_zero ? {XLEN{1'b1}} : quo;
                    hi_d = rmd;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                launch = start_i;
            end
            default: state_d = S_IDLE;
        endcase
        if (launch) begin
            state_d = launch_state;
            op_d    = op_i;
            cnt_d   = '0;
            acc_d   = launch_acc;
            m_d     = launch_m;
            sa_d    = in_sa;
            sb_d    = in_sb;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: results are queued at launch and
// compared when done pulses, including start-to-done latency.
module tb_hilo_muldiv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op_s;
    logic [31:0] opa, opb, wd;
    logic        hi_we, lo_we;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t me;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_done = 0;
    int   done_before;

    hilo_muldiv #(.XLEN(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .op_i         (op_s),
        .operand_a_i  (opa),
        .operand_b_i  (opb),
        .hi_we_i      (hi_we),
        .lo_we_i      (lo_we),
        .write_data_i (wd),
        .busy_o       (busy),
        .done_o       (done),
        .div_zero_o   (dz),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        longint sa, sb, qq, rr;
        e.dz = 1'b0;
        e.cyc = 0;
        e.lat = 33;
`ifdef HILO_MULDIV_FAST_MULT_EN
        if (!op[1]) e.lat = 1;
`endif
        case (op)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = sa * sb;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                    e.dz = 1'b1;
                end else begin
                    if (op == 2'b10) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'b0, a});
                        sb = longint'({32'b0, b});
                    end
                    qq = sa / sb;
                    rr = sa % sb;
                    p = qq;
                    e.lo = p[31:0];
                    p = rr;
                    e.hi = p[31:0];
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                me = sb_q.pop_front();
                chk("hi", hi, me.hi);
                chk("lo", lo, me.lo);
                chk("div_zero", dz, me.dz);
                chk("latency", cyc - me.cyc, me.lat);
            end
        end
    end

    task automatic launch(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit push);
        exp_t e;
        e = model(op, a, b);
        @(negedge clk);
        start = 1'b1;
        op_s = op;
        opa = a;
        opb = b;
        @(posedge clk);
        #1;
        e.cyc = cyc;
        if (push) sb_q.push_back(e);
        start = 1'b0;
        opa = $urandom;
        opb = $urandom;
        op_s = 2'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic mt(input logic [31:0] hv, input logic [31:0] lv);
        @(negedge clk);
        hi_we = 1'b1;
        wd = hv;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wd = lv;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        chk("mthi", hi, hv);
        chk("mtlo", lo, lv);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        start = 1'b0;
        op_s = 2'b00;
        opa = '0;
        opb = '0;
        wd = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", dz, 0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        mt(32'hDEAD_BEEF, 32'h0BAD_F00D);

        launch(2'b01, 32'd3, 32'd5, 1'b0);
        repeat (10) @(negedge clk);
        done_before = n_done;
        rst_n = 1'b0;
        #1;
        chk("midrun_busy", busy, 0);
        chk("midrun_hi", hi, 0);
        chk("midrun_lo", lo, 0);
        chk("midrun_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_rst", n_done, done_before);

        launch(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1);         drain();
        launch(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b1);         drain();
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); drain();
        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);         drain();
        launch(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1);         drain();
        launch(2'b11, 32'd100, 32'd7, 1'b1);               drain();
        launch(2'b11, 32'h1234_5678, 32'd0, 1'b1);         drain();
        launch(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1);         drain();
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); drain();

        mt(32'h1111_1111, 32'h2222_2222);
        launch(2'b11, 32'd1000, 32'd3, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op_s = 2'b00;
        opa = 32'd7;
        opb = 32'd9;
        hi_we = 1'b1;
        wd = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        chk("busy_hold", busy, 1);
        chk("hi_guard", hi, 32'h1111_1111);
        drain();

        e = model(2'b11, 32'd9, 32'd2);
        @(negedge clk);
        start = 1'b1;
        op_s = 2'b11;
        opa = 32'd9;
        opb = 32'd2;
        hi_we = 1'b1;
        wd = 32'hCAFE_0001;
        @(posedge clk);
        #1;
        e.cyc = cyc;
        sb_q.push_back(e);
        start = 1'b0;
        hi_we = 1'b0;
        chk("mthi_with_start", hi, 32'hCAFE_0001);
        drain();

        launch(2'b11, 32'd100, 32'd7, 1'b1);
        repeat (32) @(posedge clk);
        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("b2b_busy", busy, 1);
        drain();

        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = $urandom_range(1, 20);
            if (i % 4 == 3) rb = 32'd0;
            launch(rop, ra, rb, 1'b1);
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
